// File: rtl/mem_access_unit.sv
// mem_access_unit
//  MEM-stage data-memory access controller for the 16-bit pipeline. Loads and stores are
//  issued to a variable-latency data memory over a one-cycle mem_en request and a mem_ack
//  completion. The pipeline is stalled (stall_n=0) until the access finishes. Non-memory
//  instructions pass straight through with zero latency.
//
//  Optional feature: define MEM_PERF_CNT_EN to add the saturating perf_stall_cnt output,
//  which counts cycles with stall_n=0.
//
//  Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             kill the instruction currently in MEM
//   in_valid          EX/MEM holds a valid instruction
//   MemRead/MemWrite  load / store (both set: store)
//   WriteReg_in       instruction writes the register file
//   addr_in, wdata_in effective address, store data
//   mem_en, mem_wr    request strobe (one cycle) and direction (1=write)
//   mem_addr/wdata    request address / write data, valid with mem_en
//   mem_ack, rdata    access complete, read data valid with mem_ack
//   stall_n           0 = hold EX/MEM and WB_data
//   WriteReg_out      register-file write enable towards WB_data
//   ALU_res_out       addr_in passed through combinationally
//   data_mem_out      last loaded data (rdata_q)
//   mem_err           sticky timeout flag
//   perf_stall_cnt    stall-cycle counter (MEM_PERF_CNT_EN only)
module mem_access_unit #(
    parameter int unsigned MEM_TIMEOUT = 63
`ifdef MEM_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        WriteReg_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        stall_n,
    output logic        WriteReg_out,
    output logic [15:0] ALU_res_out,
    output logic [15:0] data_mem_out,
    output logic        mem_err
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        kill_q, kill_d;
    logic        wr_q, wr_d;          // direction of the access in flight
    logic        err_new_q, err_new_d; // in-flight access timed out
    logic        mem_err_q, mem_err_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mem_op;

    assign mem_op       = in_valid & (MemRead | MemWrite);
    assign mem_addr     = addr_in;
    assign mem_wdata    = wdata_in;
    assign ALU_res_out  = addr_in;
    assign data_mem_out = rdata_q;
    assign mem_err      = mem_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= 8'd0;
            kill_q     <= 1'b0;
            wr_q       <= 1'b0;
            err_new_q  <= 1'b0;
            mem_err_q  <= 1'b0;
            rdata_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            kill_q     <= kill_d;
            wr_q       <= wr_d;
            err_new_q  <= err_new_d;
            mem_err_q  <= mem_err_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        kill_d       = kill_q;
        wr_d         = wr_q;
        err_new_d    = err_new_q;
        mem_err_d    = mem_err_q;
        rdata_d      = rdata_q;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        stall_n      = 1'b1;
        WriteReg_out = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_op && !flush) begin
                    mem_en     = 1'b1;
                    mem_wr     = MemWrite;
                    stall_n    = 1'b0;
                    wait_cnt_d = 8'd0;
                    wr_d       = MemWrite;
                    err_new_d  = 1'b0;
                    kill_d     = 1'b0;
                    state_d    = StWait;
                end else begin
                    // A flushed memory op also lands here and gets WriteReg_out=0.
                    WriteReg_out = WriteReg_in & in_valid & ~flush;
                end
            end
            StWait: begin
                stall_n    = 1'b0;
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (flush) begin
                    kill_d = 1'b1;
                end
                // An ack on the last allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    if (!wr_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StDone;
                end else if (wait_cnt_d == TimeoutCnt) begin
                    mem_err_d = 1'b1;
                    err_new_d = 1'b1;
                    rdata_d   = 16'h0000;
                    state_d   = StDone;
                end
            end
            StDone: begin
                WriteReg_out = WriteReg_in & ~kill_q & ~flush & ~err_new_q;
                kill_d       = 1'b0;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs take their idle values while reset is held, even if EX/MEM shows a memory op.
        if (!rst_n) begin
            mem_en       = 1'b0;
            mem_wr       = 1'b0;
            stall_n      = 1'b1;
            WriteReg_out = 1'b0;
        end
    end

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
        end else if (!stall_n && (perf_stall_cnt != {PERF_W{1'b1}})) begin
            perf_stall_cnt <= perf_stall_cnt + {{(PERF_W - 1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush, in_valid, MemRead, MemWrite, WriteReg_in;
    logic [15:0] addr_in, wdata_in;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        stall_n, WriteReg_out;
    logic [15:0] ALU_res_out, data_mem_out;
    logic        mem_err;
`ifdef MEM_PERF_CNT_EN
    logic [15:0] perf_stall_cnt;
`endif

    mem_access_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .WriteReg_in (WriteReg_in),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .stall_n     (stall_n),
        .WriteReg_out(WriteReg_out),
        .ALU_res_out (ALU_res_out),
        .data_mem_out(data_mem_out),
        .mem_err     (mem_err)
`ifdef MEM_PERF_CNT_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wreg;
        logic [15:0] alu;
        logic [15:0] data;
        logic        err;
        int          stall;
    } ret_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    ret_t        ret_q[$];
    req_t        req_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        mon_en = 1'b0;
    int          stall_seen = 0;
    logic [15:0] model_rdata;
    logic        model_err;
    ret_t        mon_ret;
    req_t        mon_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: checks every request strobe and every retiring (stall_n=1) cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_en) begin
                if (req_q.size() == 0) begin
                    check("unexpected_mem_en", 32'(mem_en), 32'd0);
                end else begin
                    mon_req = req_q.pop_front();
                    check("mem_wr", 32'(mem_wr), 32'(mon_req.wr));
                    check("mem_addr", 32'(mem_addr), 32'(mon_req.addr));
                    check("mem_wdata", 32'(mem_wdata), 32'(mon_req.wdata));
                end
            end
            if (!stall_n) begin
                stall_seen++;
            end else begin
                if (ret_q.size() == 0) begin
                    check("unexpected_retire", 32'(stall_n), 32'd0);
                end else begin
                    mon_ret = ret_q.pop_front();
                    check("WriteReg_out", 32'(WriteReg_out), 32'(mon_ret.wreg));
                    check("ALU_res_out", 32'(ALU_res_out), 32'(mon_ret.alu));
                    check("data_mem_out", 32'(data_mem_out), 32'(mon_ret.data));
                    check("mem_err", 32'(mem_err), 32'(mon_ret.err));
                    check("stall_cycles", 32'(stall_seen), 32'(mon_ret.stall));
                end
                stall_seen = 0;
            end
        end
    end

    // One instruction. delay = cycles from mem_en to mem_ack (0 = never acks).
    // fl_wait = WAIT cycle (1-based) that sees flush, 0 = none. Called and returns at posedge+1.
    task automatic run_instr(input logic v, input logic rd, input logic wr, input logic wreg,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] rdat, input int delay, input logic fl0,
                             input int fl_wait, input logic fl_done, input logic spur);
        ret_t e;
        req_t r;
        int   w;
        logic killed;
        in_valid    = v;
        MemRead     = rd;
        MemWrite    = wr;
        WriteReg_in = wreg;
        addr_in     = addr;
        wdata_in    = wdata;
        mem_rdata   = 16'($urandom);
        e.alu       = addr;
        if (!(v && (rd || wr)) || fl0) begin
            e.wreg  = wreg & v & ~fl0;
            e.stall = 0;
            e.data  = model_rdata;
            e.err   = model_err;
            ret_q.push_back(e);
            flush   = fl0;
            mem_ack = spur;
            @(posedge clk);
            #1;
        end else begin
            w      = (delay == 0) ? int'(TIMEOUT) : delay;
            killed = (fl_wait >= 1) && (fl_wait <= w);
            r.wr    = wr;
            r.addr  = addr;
            r.wdata = wdata;
            req_q.push_back(r);
            if (delay == 0) begin
                model_err   = 1'b1;
                model_rdata = 16'h0000;
            end else if (!wr) begin
                model_rdata = rdat;
            end
            e.wreg  = wreg & ~killed & ~fl_done & (delay != 0);
            e.stall = w + 1;
            e.data  = model_rdata;
            e.err   = model_err;
            ret_q.push_back(e);
            flush   = 1'b0;
            mem_ack = spur;
            @(posedge clk);
            #1;
            for (int c = 1; c <= w; c++) begin
                flush     = (c == fl_wait);
                mem_ack   = (delay != 0) && (c == w);
                mem_rdata = (c == w) ? rdat : 16'($urandom);
                @(posedge clk);
                #1;
            end
            flush   = fl_done;
            mem_ack = spur;
            @(posedge clk);
            #1;
        end
        flush   = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        flush = 0; in_valid = 0; MemRead = 0; MemWrite = 0; WriteReg_in = 0;
        addr_in = 0; wdata_in = 0; mem_ack = 0; mem_rdata = 0;
        model_rdata = 16'h0000;
        model_err   = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_stall_n", 32'(stall_n), 32'd1);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_WriteReg_out", 32'(WriteReg_out), 32'd0);
        check("rst_data_mem_out", 32'(data_mem_out), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1 mon_en = 1'b1;

        // Directed cases
        run_instr(1, 0, 0, 1, 16'h1234, 16'h0000, 16'h0000, 1, 0, 0, 0, 0); // ALU op
        run_instr(1, 1, 0, 1, 16'h0040, 16'h0000, 16'hBEEF, 3, 0, 0, 0, 0); // load
        run_instr(1, 0, 1, 0, 16'h0010, 16'hA5A5, 16'h7777, 1, 0, 0, 0, 0); // store
        run_instr(1, 1, 0, 1, 16'h0020, 16'h0000, 16'h1111, 2, 0, 1, 0, 0); // flush in WAIT
        run_instr(1, 1, 0, 1, 16'h0030, 16'h0000, 16'h2222, 0, 0, 0, 0, 0); // timeout
        run_instr(1, 1, 0, 1, 16'h0050, 16'h0000, 16'h5A5A, 2, 0, 0, 0, 1); // after error
        run_instr(1, 1, 1, 1, 16'h0060, 16'hC3C3, 16'h9999, 1, 0, 0, 0, 0); // both -> write
        run_instr(1, 1, 0, 1, 16'h0070, 16'h0000, 16'h3333, 1, 1, 0, 0, 0); // flush in IDLE
        run_instr(1, 1, 0, 1, 16'h0080, 16'h0000, 16'h4444, 4, 0, 0, 1, 0); // flush in DONE

        for (int i = 0; i < 300; i++) begin
            run_instr(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                      16'($urandom), 16'($urandom), 16'($urandom),
                      ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT)),
                      ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, TIMEOUT)) : 0,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end
        mon_en = 1'b0;
        in_valid = 0; MemRead = 0; MemWrite = 0;
        check("ret_queue_drained", 32'(ret_q.size()), 32'd0);
        check("req_queue_drained", 32'(req_q.size()), 32'd0);

        // Reset in the middle of a load; a late ack must not be captured.
        in_valid = 1; MemRead = 1; MemWrite = 0; WriteReg_in = 1; addr_in = 16'h0090;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_stall_n", 32'(stall_n), 32'd1);
        check("midrst_mem_en", 32'(mem_en), 32'd0);
        check("midrst_WriteReg_out", 32'(WriteReg_out), 32'd0);
        check("midrst_mem_err", 32'(mem_err), 32'd0);
        in_valid = 0; MemRead = 0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        check("late_ack_data", 32'(data_mem_out), 32'd0);
        check("late_ack_stall_n", 32'(stall_n), 32'd1);
        check("late_ack_mem_en", 32'(mem_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
